hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline hazard controller and multi-cycle M-extension sequencer for the five-stage core.
- Watches the instruction in decode (B side) and the decoded instruction register (C side), plus the redirect from execute.
- Drives stall/flush enables for the fetch, B and C pipeline registers.
- Sequences iterative MUL/DIV ops: holds the pipeline for a fixed latency and hands start/done strobes to the multiply/divide unit.

Parameters:
MUL_CYCLES, 2, execute occupancy of MUL/MULH* ops in cycles; legal range 2..63
DIV_CYCLES, 33, execute occupancy of DIV/DIVU/REM/REMU ops in cycles; legal range 2..63
CNT_W, 6, latency counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
Rs1B  in  5  rs1 field of instruction in decode
Rs2B  in  5  rs2 field of instruction in decode
UseRs1B  in  1  decode instruction reads rs1
UseRs2B  in  1  decode instruction reads rs2
RdC  in  5  destination of C-stage instruction
RegWriteC  in  1  C-stage instruction writes a register
ResultSrcC  in  2  C-stage result select; 2'b01 = load
MdOpC  in  1  C-stage instruction is M-extension (ALUControlC[4] with ALUOpC = 2'b01)
MdDivC  in  1  M-extension op is div/rem (Funct3C[2])
PcRedirectE  in  1  taken branch or jump resolved this cycle
StallF  out  1  hold PC register
StallD  out  1  hold B-stage register
StallC  out  1  hold C-stage register
FlushD  out  1  load bubble into B-stage register at next edge
FlushC  out  1  load bubble (all control zero) into C-stage register at next edge
MdStart  out  1  one-cycle start strobe to mul/div unit
MdBusy  out  1  mul/div sequence in progress
MdDone  out  1  one-cycle strobe; mul/div result valid this cycle

Behaviour:
- Reset:
  - While rst=1 at a rising edge: state <= IDLE, cnt <= 0.
  - All outputs are 0 in any cycle where state=IDLE and no input condition applies; directly after reset all outputs are 0.
  - Reset mid-sequence aborts the sequence; the C-stage op is not resumed unless MdOpC is still high after reset, in which case a fresh full-length sequence starts.
- FSM states: IDLE, RUN, DONE.
  - Let LAT = MdDivC ? DIV_CYCLES : MUL_CYCLES, sampled in the start cycle.
  - IDLE & MdOpC & !PcRedirectE (start cycle): MdStart=1, MdBusy=1, StallF=StallD=StallC=1; next RUN, cnt <= LAT-1.
  - RUN: MdBusy=1, StallF=StallD=StallC=1. If cnt==1, next DONE; else cnt <= cnt-1.
  - DONE: MdDone=1, all stalls 0, so the C stage advances at the end of this cycle; next IDLE unconditionally. MdOpC is still high in DONE and must not retrigger.
- Timing contract: the M op occupies C for exactly LAT+1 cycles; stalls and MdBusy are high for exactly LAT cycles; MdDone rises LAT cycles after MdStart.
- Back-to-back M ops: the next op enters C after DONE; IDLE starts it in the following cycle with no extra gap.
- Load-use, evaluated in IDLE only:
  - Condition: RegWriteC & ResultSrcC==2'b01 & RdC!=0 & ((UseRs1B & Rs1B==RdC) | (UseRs2B & Rs2B==RdC)).
  - Response: StallF=StallD=1, FlushC=1, StallC=0, for a one-cycle bubble.
  - Condition is masked during RUN and DONE.
- Redirect, highest priority, in IDLE only:
  - PcRedirectE=1 forces FlushD=1 and FlushC=1, with StallF=StallD=StallC=0.
  - Suppresses load-use stall and M-op start in the same cycle.
- Simultaneous MdOpC and load-use in IDLE: the M-op start wins. Stalls cover the load-use case; FlushC=0.
- x0 never creates a hazard.
- Outputs are combinational from state, cnt and inputs. Only state and cnt are registered.

Test Plan:
1. Load-use: IDLE, RegWriteC=1, ResultSrcC=01, RdC=5, Rs1B=5, UseRs1B=1 -> StallF=StallD=FlushC=1, StallC=0 for exactly 1 cycle; same stimulus with RdC=0 or UseRs1B=0 -> all outputs 0.
2. MUL with MUL_CYCLES=2, MdOpC=1, MdDivC=0 held -> MdStart at cycle 0; StallF/D/C and MdBusy high at cycles 0-1; MdDone=1 with stalls low at cycle 2; no retrigger at cycle 3 after MdOpC drops.
3. DIV with default 33 then MUL back-to-back -> stalls high 33 cycles, MdDone at cycle 33; MdStart for MUL at cycle 34; MdDone at cycle 36.
4. PcRedirectE=1 together with the load-use condition -> FlushD=FlushC=1, StallF=StallD=StallC=0; PcRedirectE=1 with MdOpC=1 -> MdStart=0, state stays IDLE.
5. MdOpC=1 with simultaneous load-use match -> MdStart=1, StallC=1, FlushC=0.
6. rst=1 at RUN cycle 10 of a DIV -> next cycle all outputs 0 and state IDLE; rst released with MdOpC=1 -> new MdStart, full 33-cycle stall, MdDone 33 cycles later.

Source files
------------

// File: rtl/hazard_sched_if.sv
// Hazard/mul-div sequencer bundle: decode/C-stage operand info and redirect in, stall/flush/md strobes out.
// The pipeline side uses master; the scheduler uses slave.
interface hazard_sched_if;
    logic [4:0] Rs1B;
    logic [4:0] Rs2B;
    logic       UseRs1B;
    logic       UseRs2B;
    logic [4:0] RdC;
    logic       RegWriteC;
    logic [1:0] ResultSrcC;
    logic       MdOpC;
    logic       MdDivC;
    logic       PcRedirectE;
    logic       StallF;
    logic       StallD;
    logic       StallC;
    logic       FlushD;
    logic       FlushC;
    logic       MdStart;
    logic       MdBusy;
    logic       MdDone;

    modport master (
        output Rs1B, Rs2B, UseRs1B, UseRs2B, RdC, RegWriteC, ResultSrcC,
               MdOpC, MdDivC, PcRedirectE,
        input  StallF, StallD, StallC, FlushD, FlushC, MdStart, MdBusy, MdDone
    );

    modport slave (
        input  Rs1B, Rs2B, UseRs1B, UseRs2B, RdC, RegWriteC, ResultSrcC,
               MdOpC, MdDivC, PcRedirectE,
        output StallF, StallD, StallC, FlushD, FlushC, MdStart, MdBusy, MdDone
    );
endinterface

// File: rtl/hazard_sched.sv
// Pipeline hazard control plus fixed-latency mul/div sequencer; outputs are combinational from state/cnt/inputs.
// An M op holds F/D/C stalled for LAT cycles and MdDone fires LAT cycles after MdStart; redirect outranks everything.
module hazard_sched #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input logic         clk,
    input logic         rst,
    hazard_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // x0 is hardwired zero, so a load into it never produces a dependency
    assign load_use = bus.RegWriteC && (bus.ResultSrcC == 2'b01) && (bus.RdC != 5'd0) &&
                      ((bus.UseRs1B && (bus.Rs1B == bus.RdC)) ||
                       (bus.UseRs2B && (bus.Rs2B == bus.RdC)));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bus.StallF  = 1'b0;
        bus.StallD  = 1'b0;
        bus.StallC  = 1'b0;
        bus.FlushD  = 1'b0;
        bus.FlushC  = 1'b0;
        bus.MdStart = 1'b0;
        bus.MdBusy  = 1'b0;
        bus.MdDone  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.PcRedirectE) begin
                    bus.FlushD = 1'b1;
                    bus.FlushC = 1'b1;
                end else if (bus.MdOpC) begin
                    // the full stall also covers any coincident load-use hazard
                    bus.MdStart = 1'b1;
                    bus.MdBusy  = 1'b1;
                    bus.StallF  = 1'b1;
                    bus.StallD  = 1'b1;
                    bus.StallC  = 1'b1;
                    state_nxt   = RUN;
                    cnt_nxt     = bus.MdDivC ? DIV_INIT : MUL_INIT;
                end else if (load_use) begin
                    bus.StallF = 1'b1;
                    bus.StallD = 1'b1;
                    bus.FlushC = 1'b1;
                end
            end
            RUN: begin
                bus.MdBusy = 1'b1;
                bus.StallF = 1'b1;
                bus.StallD = 1'b1;
                bus.StallC = 1'b1;
                if (cnt == CNT_ONE) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            DONE: begin
                // MdOpC is still asserted here; returning to IDLE lets C advance first
                bus.MdDone = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: expected output vectors are queued per cycle and checked at the falling edge.
module tb_hazard_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_sched_if bus ();

    hazard_sched #(.MUL_CYCLES(2), .DIV_CYCLES(33), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, StallC, FlushD, FlushC, MdStart, MdBusy, MdDone}
    localparam logic [7:0] E_IDLE  = 8'b0000_0000;
    localparam logic [7:0] E_START = 8'b1110_0110;
    localparam logic [7:0] E_RUN   = 8'b1110_0010;
    localparam logic [7:0] E_DONE  = 8'b0000_0001;
    localparam logic [7:0] E_LU    = 8'b1100_1000;
    localparam logic [7:0] E_RD    = 8'b0001_1000;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    function automatic logic [7:0] observed();
        return {bus.StallF, bus.StallD, bus.StallC, bus.FlushD, bus.FlushC,
                bus.MdStart, bus.MdBusy, bus.MdDone};
    endfunction

    task automatic expect_out(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cycle();
        logic [7:0] e;
        logic [7:0] o;
        string      t;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = observed();
            total++;
            assert (o === e) passed++;
            else $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Rs1B        = 5'd0;
        bus.Rs2B        = 5'd0;
        bus.UseRs1B     = 1'b0;
        bus.UseRs2B     = 1'b0;
        bus.RdC         = 5'd0;
        bus.RegWriteC   = 1'b0;
        bus.ResultSrcC  = 2'b00;
        bus.MdOpC       = 1'b0;
        bus.MdDivC      = 1'b0;
        bus.PcRedirectE = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
        bus.RegWriteC  = 1'b1;
        bus.ResultSrcC = 2'b01;
        bus.RdC        = rd;
        bus.Rs1B       = rs1;
        bus.UseRs1B    = use1;
    endtask

    // Full M-op sequence: start cycle, lat-1 RUN cycles, then DONE with MdOpC still high
    task automatic md_seq(input string tag, input logic div, input int lat);
        bus.MdOpC  = 1'b1;
        bus.MdDivC = div;
        expect_out({tag, "_start"}, E_START);
        cycle();
        for (int i = 1; i < lat; i++) begin
            expect_out($sformatf("%s_run%0d", tag, i), E_RUN);
            cycle();
        end
        expect_out({tag, "_done"}, E_DONE);
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", E_IDLE);
        cycle();
        rst = 1'b0;
        expect_out("post_reset", E_IDLE);
        cycle();

        // load-use on rs1, then on rs2, then the non-hazard variants
        set_load_use(5'd5, 5'd5, 1'b1);
        expect_out("lu_rs1", E_LU);
        cycle();
        clear_inputs();
        expect_out("lu_bubble_gone", E_IDLE);
        cycle();
        set_load_use(5'd7, 5'd3, 1'b0);
        bus.Rs2B    = 5'd7;
        bus.UseRs2B = 1'b1;
        expect_out("lu_rs2", E_LU);
        cycle();
        clear_inputs();
        set_load_use(5'd0, 5'd0, 1'b1);
        expect_out("lu_x0", E_IDLE);
        cycle();
        set_load_use(5'd5, 5'd5, 1'b0);
        expect_out("lu_unused", E_IDLE);
        cycle();
        set_load_use(5'd5, 5'd5, 1'b1);
        bus.ResultSrcC = 2'b00;
        expect_out("lu_not_load", E_IDLE);
        cycle();
        clear_inputs();

        // single MUL, no retrigger after DONE
        md_seq("mul", 1'b0, 2);
        bus.MdOpC = 1'b0;
        expect_out("mul_no_retrigger", E_IDLE);
        cycle();

        // DIV then MUL back-to-back
        md_seq("div", 1'b1, 33);
        md_seq("b2b_mul", 1'b0, 2);
        clear_inputs();
        expect_out("b2b_idle", E_IDLE);
        cycle();

        // redirect beats load-use and M-op start
        set_load_use(5'd9, 5'd9, 1'b1);
        bus.PcRedirectE = 1'b1;
        expect_out("redir_lu", E_RD);
        cycle();
        clear_inputs();
        bus.PcRedirectE = 1'b1;
        bus.MdOpC       = 1'b1;
        expect_out("redir_md", E_RD);
        cycle();
        bus.PcRedirectE = 1'b0;
        md_seq("after_redir", 1'b0, 2);
        clear_inputs();

        // M-op start with coincident load-use; load-use stays masked through RUN/DONE
        set_load_use(5'd12, 5'd12, 1'b1);
        md_seq("md_lu", 1'b0, 2);
        clear_inputs();
        expect_out("md_lu_idle", E_IDLE);
        cycle();

        // reset during RUN cycle 10 of a DIV
        bus.MdOpC  = 1'b1;
        bus.MdDivC = 1'b1;
        expect_out("abort_start", E_START);
        cycle();
        for (int i = 1; i < 10; i++) begin
            expect_out($sformatf("abort_run%0d", i), E_RUN);
            cycle();
        end
        rst = 1'b1;
        expect_out("abort_run10_rst", E_RUN);
        cycle();
        rst       = 1'b0;
        bus.MdOpC = 1'b0;
        expect_out("abort_idle", E_IDLE);
        cycle();
        md_seq("restart_div", 1'b1, 33);
        clear_inputs();
        expect_out("final_idle", E_IDLE);
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
